// File: rtl/mod_exp_pkg.sv
// Shared types and constants for the Montgomery modular exponentiator.
package mod_exp_pkg;

    // Top-level sequencing: each Mont state names the multiplication in flight.
    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StToMontB,
        StToMont1,
        StLoop,
        StFromMont,
        StDone
    } exp_state_e;

    // Bit-serial multiplier phases.
    typedef enum logic [1:0] {
        MmIdle,
        MmIter,
        MmSub
    } mm_state_e;

    // Value driven on err when the operands are rejected.
    localparam logic ErrIllegal = 1'b1;

    // One load cycle, WIDTH iterations, one conditional subtract.
    function automatic int unsigned mm_cycles(input int unsigned w);
        return w + 2;
    endfunction

endpackage

// File: rtl/mont_mul_serial.sv
// Radix-2 interleaved Montgomery multiplier: p = a*b*2^-WIDTH mod n.
// go is sampled only while idle; rdy pulses for one cycle with p valid.
module mont_mul_serial
    import mod_exp_pkg::*;
#(
    parameter int unsigned WIDTH = 65
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic             rdy,
    output logic [WIDTH-1:0] p
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastIter = CntW'(WIDTH - 1);

    mm_state_e        state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, n_q;
    logic [WIDTH+1:0] s_q, s_add, s_red, s_sub, b_ext, n_ext;
    logic [CntW-1:0]  cnt_q;
    logic             rdy_q;

    assign b_ext = {2'b00, b_q};
    assign n_ext = {2'b00, n_q};

    // Phase sequencing: load on go, WIDTH iterations, then the final reduction.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            MmIdle:  if (go) state_d = MmIter;
            MmIter:  if (cnt_q == LastIter) state_d = MmSub;
            MmSub:   state_d = MmIdle;
            default: state_d = MmIdle;
        endcase
    end

    // Accumulator step (add a_i*b, make even with n) and final s >= n correction.
    always_comb begin
        s_add = s_q + (a_q[0] ? b_ext : '0);
        s_red = s_add + (s_add[0] ? n_ext : '0);
        s_sub = (s_q >= n_ext) ? (s_q - n_ext) : s_q;
    end

    // Operand, accumulator and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MmIdle;
            a_q     <= '0;
            b_q     <= '0;
            n_q     <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= 1'b0;
            unique case (state_q)
                MmIdle: begin
                    if (go) begin
                        a_q   <= a;
                        b_q   <= b;
                        n_q   <= n;
                        s_q   <= '0;
                        cnt_q <= '0;
                    end
                end
                MmIter: begin
                    s_q   <= s_red >> 1;
                    a_q   <= a_q >> 1;
                    cnt_q <= cnt_q + 1'b1;
                end
                MmSub: begin
                    s_q   <= s_sub;
                    rdy_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign rdy = rdy_q;
    assign p   = s_q[WIDTH-1:0];

endmodule

// File: rtl/mod_exp_mont_p.sv
// Runtime-keyed Montgomery exponentiator: result = base^exp mod mod_n.
// Right-to-left square-and-multiply around one shared bit-serial multiplier.
module mod_exp_mont_p
    import mod_exp_pkg::*;
#(
    parameter int unsigned WIDTH = 65
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] exp,
    input  logic [WIDTH-1:0] mod_n,
    input  logic [WIDTH-1:0] r2_mod,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             err
);

    localparam logic [WIDTH-1:0] One = WIDTH'(1);

    exp_state_e       state_q, state_d;
    logic [WIDTH-1:0] base_q, n_q, r2_q;
    logic [WIDTH-1:0] e_q, e_d, x_q, x_d, b_q, b_d, result_q, result_d;
    logic             sq_q, sq_d, err_q, err_d, done_q, done_d;
    logic             accept, illegal;
    logic             do_top, do_step;
    logic [WIDTH-1:0] x_cur, b_cur, e_sh;
    logic             mm_go, mm_rdy;
    logic [WIDTH-1:0] mm_a, mm_b, mm_p;

    assign busy    = (state_q != StIdle) || done_q;
    assign accept  = start && !busy;
    assign illegal = !n_q[0] || (n_q <= One) || (base_q >= n_q);

    mont_mul_serial #(
        .WIDTH (WIDTH)
    ) u_mm (
        .clk   (clk),
        .rst_n (rst_n),
        .go    (mm_go),
        .a     (mm_a),
        .b     (mm_b),
        .n     (n_q),
        .rdy   (mm_rdy),
        .p     (mm_p)
    );

    // Sequencing; every next multiplication is launched in the rdy cycle of the previous one.
    always_comb begin
        state_d  = state_q;
        e_d      = e_q;
        x_d      = x_q;
        b_d      = b_q;
        sq_d     = sq_q;
        result_d = result_q;
        err_d    = err_q;
        done_d   = 1'b0;
        mm_go    = 1'b0;
        mm_a     = x_q;
        mm_b     = b_q;
        do_top   = 1'b0;
        do_step  = 1'b0;
        x_cur    = x_q;
        b_cur    = b_q;
        e_sh     = e_q >> 1;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d  = StCheck;
                    e_d      = exp;
                    result_d = '0;
                    err_d    = 1'b0;
                end
            end
            StCheck: begin
                if (illegal) begin
                    err_d    = ErrIllegal;
                    result_d = '0;
                    state_d  = StDone;
                end else begin
                    mm_go   = 1'b1;
                    mm_a    = base_q;
                    mm_b    = r2_q;
                    state_d = StToMontB;
                end
            end
            StToMontB: begin
                if (mm_rdy) begin
                    b_d     = mm_p;
                    mm_go   = 1'b1;
                    mm_a    = One;
                    mm_b    = r2_q;
                    state_d = StToMont1;
                end
            end
            StToMont1: begin
                if (mm_rdy) begin
                    x_d    = mm_p;
                    x_cur  = mm_p;
                    do_top = 1'b1;
                end
            end
            StLoop: begin
                if (mm_rdy) begin
                    if (sq_q) begin
                        b_d    = mm_p;
                        b_cur  = mm_p;
                        do_top = 1'b1;
                    end else begin
                        x_d     = mm_p;
                        x_cur   = mm_p;
                        do_step = 1'b1;
                    end
                end
            end
            StFromMont: begin
                if (mm_rdy) begin
                    result_d = mm_p;
                    state_d  = StDone;
                end
            end
            StDone: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Top of a loop iteration: multiply if the low exponent bit is set, else shift.
        if (do_top) begin
            if (e_q[0]) begin
                mm_go   = 1'b1;
                mm_a    = x_cur;
                mm_b    = b_cur;
                sq_d    = 1'b0;
                state_d = StLoop;
            end else begin
                do_step = 1'b1;
            end
        end

        // Shift the exponent; square while bits remain, otherwise leave Montgomery form.
        if (do_step) begin
            e_d   = e_sh;
            mm_go = 1'b1;
            if (e_sh != '0) begin
                mm_a    = b_cur;
                mm_b    = b_cur;
                sq_d    = 1'b1;
                state_d = StLoop;
            end else begin
                mm_a    = x_cur;
                mm_b    = One;
                state_d = StFromMont;
            end
        end
    end

    // State, working values and output registers; operands are captured on accept only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            base_q   <= '0;
            n_q      <= '0;
            r2_q     <= '0;
            e_q      <= '0;
            x_q      <= '0;
            b_q      <= '0;
            sq_q     <= 1'b0;
            result_q <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            e_q      <= e_d;
            x_q      <= x_d;
            b_q      <= b_d;
            sq_q     <= sq_d;
            result_q <= result_d;
            err_q    <= err_d;
            done_q   <= done_d;
            if (accept) begin
                base_q <= base;
                n_q    <= mod_n;
                r2_q   <= r2_mod;
            end
        end
    end

    assign done   = done_q;
    assign result = result_q;
    assign err    = err_q;

endmodule

// File: tb/tb_mod_exp_mont_p.sv
// Self-checking bench: directed and random exponentiations on an 8-bit and a 65-bit instance,
// compared against a plain-arithmetic modular exponentiation model.
module tb_mod_exp_mont_p;

    localparam int Limit = 20000;
    localparam logic [64:0] RsaN = 65'd21536215303153667899;
    localparam logic [64:0] RsaE = 65'd17;
    localparam logic [64:0] RsaD = 65'd11401525742632630793;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       s8_start;
    logic [7:0] s8_base, s8_exp, s8_n, s8_r2, s8_result;
    logic       s8_busy, s8_done, s8_err;

    logic        s65_start;
    logic [64:0] s65_base, s65_exp, s65_n, s65_r2, s65_result;
    logic        s65_busy, s65_done, s65_err;

    mod_exp_mont_p #(.WIDTH(8)) u_dut8 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (s8_start),
        .base   (s8_base),
        .exp    (s8_exp),
        .mod_n  (s8_n),
        .r2_mod (s8_r2),
        .busy   (s8_busy),
        .done   (s8_done),
        .result (s8_result),
        .err    (s8_err)
    );

    mod_exp_mont_p #(.WIDTH(65)) u_dut65 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (s65_start),
        .base   (s65_base),
        .exp    (s65_exp),
        .mod_n  (s65_n),
        .r2_mod (s65_r2),
        .busy   (s65_busy),
        .done   (s65_done),
        .result (s65_result),
        .err    (s65_err)
    );

    int          checks = 0;
    int          errors = 0;
    int unsigned acc_cyc = 0;
    int unsigned done_cyc = 0;

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Reference: square-and-multiply with full-width products and plain modulo.
    function automatic logic [64:0] mod_pow(input logic [64:0] b, input logic [64:0] e,
                                            input logic [64:0] n);
        logic [131:0] r, bb, nn;
        nn = {67'd0, n};
        r  = 132'd1 % nn;
        bb = {67'd0, b} % nn;
        for (int i = 0; i < 65; i++) begin
            if (e[i]) r = (r * bb) % nn;
            bb = (bb * bb) % nn;
        end
        return r[64:0];
    endfunction

    function automatic logic [64:0] r2_of(input logic [64:0] n, input int w);
        logic [131:0] t;
        t = 132'd1 << (2 * w);
        t = t % {67'd0, n};
        return t[64:0];
    endfunction

    // Accept-to-done latency: 2 + M*(W+2), M = 3 + popcount + max(bitlen-1, 0).
    function automatic int lat_model(input logic [64:0] e, input int w);
        int pc = 0;
        int bl = 0;
        for (int i = 0; i < 65; i++) begin
            if (e[i]) begin
                pc++;
                bl = i + 1;
            end
        end
        return 2 + (3 + pc + ((bl > 0) ? bl - 1 : 0)) * (w + 2);
    endfunction

    function automatic logic cur_busy(input bit wide);
        return wide ? s65_busy : s8_busy;
    endfunction

    function automatic logic cur_done(input bit wide);
        return wide ? s65_done : s8_done;
    endfunction

    function automatic logic cur_err(input bit wide);
        return wide ? s65_err : s8_err;
    endfunction

    function automatic logic [64:0] cur_result(input bit wide);
        return wide ? s65_result : {57'd0, s8_result};
    endfunction

    // Wait for busy low at a falling edge, present operands, pulse start across one rising edge.
    task automatic launch(input bit wide, input logic [64:0] b, input logic [64:0] e,
                          input logic [64:0] n, input logic [64:0] r2);
        int guard = 0;
        @(negedge clk);
        while (cur_busy(wide) && guard < Limit) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= Limit) check("launch_busy_timeout", 65'(cur_busy(wide)), 65'd0);
        if (wide) begin
            s65_base  = b;
            s65_exp   = e;
            s65_n     = n;
            s65_r2    = r2;
            s65_start = 1'b1;
        end else begin
            s8_base  = b[7:0];
            s8_exp   = e[7:0];
            s8_n     = n[7:0];
            s8_r2    = r2[7:0];
            s8_start = 1'b1;
        end
        @(posedge clk);
        #1;
        acc_cyc   = cyc;
        s8_start  = 1'b0;
        s65_start = 1'b0;
    endtask

    // Poll for done, check outputs and latency, then check the cycle after done.
    task automatic wait_done(input bit wide, input string tag, input logic [64:0] exp_res,
                             input logic exp_err, input int exp_lat);
        int k = 0;
        bit found = 1'b0;
        bit busy_ok = 1'b1;
        while (k < Limit && !found) begin
            @(posedge clk);
            #1;
            k++;
            if (!cur_busy(wide)) busy_ok = 1'b0;
            if (cur_done(wide)) found = 1'b1;
        end
        check({tag, "_done_seen"}, 65'(found), 65'd1);
        done_cyc = cyc;
        check({tag, "_result"}, cur_result(wide), exp_res);
        check({tag, "_err"}, 65'(cur_err(wide)), 65'(exp_err));
        check({tag, "_latency"}, 65'(done_cyc - acc_cyc), 65'(exp_lat));
        check({tag, "_busy_held"}, 65'(busy_ok), 65'd1);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 65'(cur_done(wide)), 65'd0);
        check({tag, "_busy_clear"}, 65'(cur_busy(wide)), 65'd0);
        check({tag, "_result_hold"}, cur_result(wide), exp_res);
    endtask

    task automatic run_case(input bit wide, input string tag, input logic [64:0] b,
                            input logic [64:0] e, input logic [64:0] n, input logic [64:0] r2,
                            input logic [64:0] exp_res, input logic exp_err, input int exp_lat);
        launch(wide, b, e, n, r2);
        wait_done(wide, tag, exp_res, exp_err, exp_lat);
    endtask

    logic [64:0] ct, r2n, msg, nn, bb, ee;
    logic [95:0] wide_rand;
    bit          saw;

    initial begin
        s8_start  = 1'b0;
        s8_base   = '0;
        s8_exp    = '0;
        s8_n      = '0;
        s8_r2     = '0;
        s65_start = 1'b0;
        s65_base  = '0;
        s65_exp   = '0;
        s65_n     = '0;
        s65_r2    = '0;

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy65", 65'(s65_busy), 65'd0);
        check("rst_done65", 65'(s65_done), 65'd0);
        check("rst_err65", 65'(s65_err), 65'd0);
        check("rst_result65", s65_result, 65'd0);
        check("rst_busy8", 65'(s8_busy), 65'd0);
        check("rst_result8", 65'(s8_result), 65'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed 8-bit cases.
        run_case(0, "w8_b3_e5", 65'd3, 65'd5, 65'd61, 65'd22, 65'd60, 1'b0, lat_model(65'd5, 8));
        run_case(0, "w8_exp0", 65'd7, 65'd0, 65'd61, 65'd22, 65'd1, 1'b0, 32);
        run_case(0, "w8_even_n", 65'd3, 65'd5, 65'd60, 65'd0, 65'd0, 1'b1, 2);
        run_case(0, "w8_base_eq_n", 65'd61, 65'd5, 65'd61, 65'd22, 65'd0, 1'b1, 2);
        run_case(0, "w8_n_one", 65'd0, 65'd3, 65'd1, 65'd0, 65'd0, 1'b1, 2);
        run_case(0, "w8_base_gt_n", 65'd200, 65'd3, 65'd61, 65'd22, 65'd0, 1'b1, 2);
        run_case(0, "w8_n255_max", 65'd254, 65'd255, 65'd255, r2_of(65'd255, 8),
                 mod_pow(65'd254, 65'd255, 65'd255), 1'b0, lat_model(65'd255, 8));

        // RSA round trip on the 65-bit instance.
        r2n = r2_of(RsaN, 65);
        ct  = mod_pow(65'd12345, RsaE, RsaN);
        run_case(1, "rsa_enc", 65'd12345, RsaE, RsaN, r2n, ct, 1'b0, lat_model(RsaE, 65));
        run_case(1, "rsa_dec", ct, RsaD, RsaN, r2n, 65'd12345, 1'b0, lat_model(RsaD, 65));

        // Random 8-bit moduli, bases and exponents.
        for (int i = 0; i < 200; i++) begin
            nn = 65'(2 * $urandom_range(1, 127) + 1);
            bb = 65'($urandom % nn);
            ee = 65'($urandom_range(0, 255));
            run_case(0, "w8_rand", bb, ee, nn, r2_of(nn, 8), mod_pow(bb, ee, nn), 1'b0,
                     lat_model(ee, 8));
        end

        // Random 65-bit messages under the public exponent.
        for (int i = 0; i < 48; i++) begin
            wide_rand = {$urandom, $urandom, $urandom};
            wide_rand = wide_rand % {31'd0, RsaN};
            msg = wide_rand[64:0];
            run_case(1, "w65_rand", msg, RsaE, RsaN, r2n, mod_pow(msg, RsaE, RsaN), 1'b0,
                     lat_model(RsaE, 65));
        end

        // Start re-pulsed while busy with new inputs: ignored; then a back-to-back accept.
        launch(0, 65'd3, 65'd5, 65'd61, 65'd22);
        repeat (5) @(negedge clk);
        s8_base  = 8'd7;
        s8_exp   = 8'd200;
        s8_n     = 8'd59;
        s8_r2    = 8'd3;
        s8_start = 1'b1;
        @(negedge clk);
        s8_start = 1'b0;
        s8_base  = 8'd9;
        wait_done(0, "busy_ignore", 65'd60, 1'b0, lat_model(65'd5, 8));
        launch(0, 65'd7, 65'd0, 65'd61, 65'd22);
        check("b2b_accept_gap", 65'(acc_cyc - done_cyc), 65'd2);
        wait_done(0, "b2b", 65'd1, 1'b0, 32);

        // Asynchronous reset in the middle of the exponent loop.
        msg = 65'd987654321;
        launch(1, msg, RsaE, RsaN, r2n);
        repeat (300) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 65'(s65_busy), 65'd0);
        check("abort_result", s65_result, 65'd0);
        check("abort_done", 65'(s65_done), 65'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (700) begin
            @(posedge clk);
            #1;
            if (s65_done || s65_busy) saw = 1'b1;
        end
        check("abort_no_done", 65'(saw), 65'd0);
        run_case(1, "post_abort", msg, RsaE, RsaN, r2n, mod_pow(msg, RsaE, RsaN), 1'b0,
                 lat_model(RsaE, 65));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
